// File: rtl/cpu_traffic_agent.sv
// Per-CPU traffic source and in-order response checker.
// Issues sequence-tagged 64-bit requests on the cpu->noc push channel and
// checks that the noc->cpu pull channel echoes them back in order.
module cpu_traffic_agent #(
  parameter int NUM_TRANSACTIONS = 16,
  parameter int MAX_OUTSTANDING  = 4,
  parameter int IDLE_GAP         = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] cpu_index,
  input  logic        data_cpu_to_noc_rdy,
  output logic        data_cpu_to_noc_vld,
  output logic [63:0] data_cpu_to_noc,
  output logic        data_noc_to_cpu_rdy,
  input  logic        data_noc_to_cpu_vld,
  input  logic [63:0] data_noc_to_cpu,
  output logic        transactions_done,
  output logic        error,
  output logic [15:0] rx_count
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int GAP_W = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;
  localparam logic [15:0]      NUM_TX   = 16'(NUM_TRANSACTIONS);
  localparam logic [OUT_W-1:0] MAX_OUT  = OUT_W'(MAX_OUTSTANDING);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IDLE_GAP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [15:0]      tx_seq, tx_seq_n;
  logic [15:0]      rx_count_n;
  logic [OUT_W-1:0] outstanding, outstanding_n;
  logic [GAP_W-1:0] gap, gap_n;
  logic             error_n;
  logic             push_fire, pull_fire, pull_ok;
  logic             vld_n;
  logic [63:0]      expected_word;
  logic             unused_cpu_index_hi;

  // Request / expected-response word layout shared by issue and check paths.
  function automatic logic [63:0] make_word(input logic [15:0] idx, input logic [15:0] seq);
    return {idx, seq, seq ^ 16'hFFFF, 16'hCAFE};
  endfunction

  assign push_fire     = data_cpu_to_noc_vld & data_cpu_to_noc_rdy;
  assign pull_fire     = data_noc_to_cpu_vld & data_noc_to_cpu_rdy;
  assign pull_ok       = pull_fire && (outstanding != '0);
  // rx_count doubles as the receive sequence number for the in-order check.
  assign expected_word = make_word(cpu_index[15:0], rx_count);
  assign unused_cpu_index_hi = ^cpu_index[31:16];

  // Next-state values for the FSM and its counters; outputs are registered from these.
  always_comb begin
    state_n       = state;
    tx_seq_n      = tx_seq;
    rx_count_n    = rx_count;
    outstanding_n = outstanding;
    gap_n         = gap;
    error_n       = error;
    case (state)
      IDLE: begin
        if (start) state_n = RUN;
      end
      RUN: begin
        if (push_fire) begin
          tx_seq_n = tx_seq + 16'd1;
          gap_n    = GAP_LOAD;
        end else if (gap != '0) begin
          gap_n = gap - GAP_W'(1);
        end
        if (pull_ok) begin
          rx_count_n = rx_count + 16'd1;
          if (data_noc_to_cpu != expected_word) error_n = 1'b1;
        end else if (pull_fire) begin
          error_n = 1'b1;
        end
        case ({push_fire, pull_ok})
          2'b10:   outstanding_n = outstanding + OUT_W'(1);
          2'b01:   outstanding_n = outstanding - OUT_W'(1);
          default: outstanding_n = outstanding;
        endcase
        if (tx_seq == NUM_TX && rx_count == NUM_TX) state_n = DONE;
      end
      DONE: begin
        state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Push valid is derived from next-cycle state so it is a clean register
  // that only drops after an accept, keeping vld/data stable under backpressure.
  assign vld_n = (state_n == RUN) && (tx_seq_n < NUM_TX) &&
                 (outstanding_n < MAX_OUT) && (gap_n == '0);

  // Single state register for the FSM, counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      tx_seq              <= '0;
      rx_count            <= '0;
      outstanding         <= '0;
      gap                 <= '0;
      error               <= 1'b0;
      data_cpu_to_noc_vld <= 1'b0;
      data_cpu_to_noc     <= '0;
      data_noc_to_cpu_rdy <= 1'b0;
      transactions_done   <= 1'b0;
    end else begin
      state               <= state_n;
      tx_seq              <= tx_seq_n;
      rx_count            <= rx_count_n;
      outstanding         <= outstanding_n;
      gap                 <= gap_n;
      error               <= error_n;
      data_cpu_to_noc_vld <= vld_n;
      data_cpu_to_noc     <= vld_n ? make_word(cpu_index[15:0], tx_seq_n) : 64'd0;
      data_noc_to_cpu_rdy <= (state_n == RUN);
      transactions_done   <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_cpu_traffic_agent.sv
// Self-checking bench for cpu_traffic_agent: a loopback responder with
// randomized backpressure and response timing, checked against a
// transaction-level model of the request sequence and outstanding window.
module tb_cpu_traffic_agent;

  localparam int N_TX    = 6;
  localparam int MAX_OUT = 2;
  localparam int GAP     = 2;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] cpu_index;
  logic        data_cpu_to_noc_rdy;
  logic        data_cpu_to_noc_vld;
  logic [63:0] data_cpu_to_noc;
  logic        data_noc_to_cpu_rdy;
  logic        data_noc_to_cpu_vld;
  logic [63:0] data_noc_to_cpu;
  logic        transactions_done;
  logic        error;
  logic [15:0] rx_count;

  int vectors;
  int miscompares;

  // Monitor state filled in by tick(); scenario tasks compare against it.
  logic [63:0] req_log[$];
  logic [63:0] resp_q[$];
  bit          push_acc, pull_acc;
  bit          held_valid;
  logic [63:0] held_word;
  int          quiet_left;
  int          model_out;
  int          stab_viol, gap_viol, limit_viol;
  int          pushes, pulls;
  bit          err_before_c, err_after_c, err_dropped;

  cpu_traffic_agent #(
    .NUM_TRANSACTIONS(N_TX),
    .MAX_OUTSTANDING (MAX_OUT),
    .IDLE_GAP        (GAP)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .start              (start),
    .cpu_index          (cpu_index),
    .data_cpu_to_noc_rdy(data_cpu_to_noc_rdy),
    .data_cpu_to_noc_vld(data_cpu_to_noc_vld),
    .data_cpu_to_noc    (data_cpu_to_noc),
    .data_noc_to_cpu_rdy(data_noc_to_cpu_rdy),
    .data_noc_to_cpu_vld(data_noc_to_cpu_vld),
    .data_noc_to_cpu    (data_noc_to_cpu),
    .transactions_done  (transactions_done),
    .error              (error),
    .rx_count           (rx_count)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so a wedged run still ends with a visible failure.
  initial begin
    #200us;
    $display("[TB] FAIL watchdog: simulation time limit reached, got hang required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // The request word for a given sequence number, built arithmetically
  // from the field layout rather than by bit concatenation.
  function automatic logic [63:0] exp_word(input int unsigned idx, input int unsigned seq);
    logic [63:0] w;
    w = (64'(idx % 65536) << 48) | (64'(seq) << 32) | (64'(65535 - seq) << 16) | 64'hCAFE;
    return w;
  endfunction

  // Advance one cycle from a negedge to the next negedge, recording which
  // handshakes happened at the posedge and any protocol observations.
  task automatic tick();
    logic        pv;
    logic [63:0] pd;
    logic        pr;
    pv = data_cpu_to_noc_vld;
    pd = data_cpu_to_noc;
    pr = data_noc_to_cpu_rdy;
    if (held_valid && (!pv || pd != held_word)) stab_viol++;
    if (quiet_left > 0) begin
      if (pv) gap_viol++;
      quiet_left--;
    end
    if (pv && model_out >= MAX_OUT) limit_viol++;
    push_acc   = pv && data_cpu_to_noc_rdy;
    pull_acc   = pr && data_noc_to_cpu_vld;
    held_valid = pv && !data_cpu_to_noc_rdy;
    held_word  = pd;
    @(posedge clk);
    @(negedge clk);
    if (pull_acc && model_out > 0) model_out--;
    if (push_acc) begin
      model_out++;
      req_log.push_back(pd);
      quiet_left = GAP;
    end
  endtask

  // Clear bench-side model state; the DUT reset is handled by the caller.
  task automatic clear_model();
    req_log.delete();
    resp_q.delete();
    push_acc = 0; pull_acc = 0; held_valid = 0; held_word = '0;
    quiet_left = 0; model_out = 0;
    stab_viol = 0; gap_viol = 0; limit_viol = 0;
    pushes = 0; pulls = 0;
    err_before_c = 0; err_after_c = 0; err_dropped = 0;
  endtask

  // Pulse reset with all inputs idle and start from a clean model.
  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    data_cpu_to_noc_rdy = 1'b0;
    data_noc_to_cpu_vld = 1'b0;
    data_noc_to_cpu = '0;
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Hold start for one cycle so the agent leaves IDLE.
  task automatic start_traffic();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Loopback responder: echoes every accepted request one cycle later
  // (optionally corrupting one), under the chosen push-ready pattern.
  // rdy_mode 0 = always ready, 1 = toggling, 2 = random.
  task automatic run_traffic(input int rdy_mode, input int corrupt_idx,
                             input int stop_pushes, input int budget,
                             output bit timed_out);
    bit          pull_v;
    bit          e0;
    logic [63:0] w;
    timed_out = 1'b1;
    for (int n = 0; n < budget; n++) begin
      if (stop_pushes > 0 && req_log.size() >= stop_pushes) begin
        timed_out = 1'b0;
        break;
      end
      if (stop_pushes == 0 && transactions_done === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      case (rdy_mode)
        0:       data_cpu_to_noc_rdy = 1'b1;
        1:       data_cpu_to_noc_rdy = (n % 2 == 0);
        default: data_cpu_to_noc_rdy = 1'($urandom_range(0, 1));
      endcase
      pull_v = (resp_q.size() > 0) && (rdy_mode != 2 || $urandom_range(0, 3) != 0);
      if (data_noc_to_cpu_vld && !pull_acc) pull_v = 1'b1;
      data_noc_to_cpu_vld = pull_v;
      data_noc_to_cpu     = pull_v ? resp_q[0] : 64'd0;
      e0 = error;
      tick();
      if (e0 && !error) err_dropped = 1'b1;
      if (pull_acc) begin
        void'(resp_q.pop_front());
        if (pulls == corrupt_idx) begin
          err_before_c = e0;
          err_after_c  = error;
        end
        pulls++;
      end
      if (push_acc) begin
        w = req_log[$];
        if (pushes == corrupt_idx) w = w ^ 64'h1;
        resp_q.push_back(w);
        pushes++;
      end
    end
    data_noc_to_cpu_vld = 1'b0;
    data_noc_to_cpu     = '0;
  endtask

  // Reset values while reset is held, then quiet IDLE after release.
  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    cpu_index = $urandom;
    data_cpu_to_noc_rdy = 1'b1;
    data_noc_to_cpu_vld = 1'b0;
    data_noc_to_cpu = '0;
    clear_model();
    repeat (3) @(negedge clk);
    vectors++;
    if ({data_cpu_to_noc_vld, data_noc_to_cpu_rdy, transactions_done, error} !== 4'b0)
      begin miscompares++; $display("[TB] FAIL reset_flags: got %b required 0000",
        {data_cpu_to_noc_vld, data_noc_to_cpu_rdy, transactions_done, error}); end
    vectors++;
    if (data_cpu_to_noc !== 64'd0)
      begin miscompares++; $display("[TB] FAIL reset_data: got %h required 0", data_cpu_to_noc); end
    vectors++;
    if (rx_count !== 16'd0)
      begin miscompares++; $display("[TB] FAIL reset_rx_count: got %0d required 0", rx_count); end
    rst_n = 1'b1;
    repeat (4) tick();
    vectors++;
    if ({data_cpu_to_noc_vld, data_noc_to_cpu_rdy, transactions_done} !== 3'b0 || req_log.size() != 0)
      begin miscompares++; $display("[TB] FAIL idle_quiet: got vld/rdy/done %b pushes %0d required 000 and 0",
        {data_cpu_to_noc_vld, data_noc_to_cpu_rdy, transactions_done}, req_log.size()); end
  endtask

  // Shared end-of-run comparisons against the model for a full run.
  task automatic test_full_run(input string name, input int rdy_mode, input int corrupt_idx);
    bit to;
    do_reset();
    cpu_index = (name == "basic_echo") ? 32'd3 : $urandom;
    start_traffic();
    if (name == "basic_echo") begin
      vectors++;
      if (data_cpu_to_noc_vld !== 1'b1 || data_cpu_to_noc !== exp_word(cpu_index, 0))
        begin miscompares++; $display("[TB] FAIL first_vld: got vld %b data %h required 1 %h",
          data_cpu_to_noc_vld, data_cpu_to_noc, exp_word(cpu_index, 0)); end
    end
    run_traffic(rdy_mode, corrupt_idx, 0, 400, to);
    vectors++;
    if (to) begin miscompares++; $display("[TB] FAIL %s_timeout: got no done required done within 400 cycles", name); end
    vectors++;
    if (req_log.size() != N_TX)
      begin miscompares++; $display("[TB] FAIL %s_req_count: got %0d required %0d", name, req_log.size(), N_TX); end
    foreach (req_log[i]) begin
      vectors++;
      if (req_log[i] !== exp_word(cpu_index, i))
        begin miscompares++; $display("[TB] FAIL %s_req_word[%0d]: got %h required %h",
          name, i, req_log[i], exp_word(cpu_index, i)); end
    end
    vectors++;
    if (rx_count !== 16'(N_TX) || transactions_done !== 1'b1)
      begin miscompares++; $display("[TB] FAIL %s_done: got rx %0d done %b required %0d 1",
        name, rx_count, transactions_done, N_TX); end
    vectors++;
    if (error !== (corrupt_idx >= 0))
      begin miscompares++; $display("[TB] FAIL %s_error: got %b required %b", name, error, corrupt_idx >= 0); end
    vectors++;
    if (stab_viol != 0 || gap_viol != 0 || limit_viol != 0)
      begin miscompares++; $display("[TB] FAIL %s_protocol: got stab %0d gap %0d limit %0d required 0 0 0",
        name, stab_viol, gap_viol, limit_viol); end
  endtask

  // In-order echo with push always ready; DONE then ignores start.
  task automatic test_basic_echo();
    test_full_run("basic_echo", 0, -1);
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    vectors++;
    if (transactions_done !== 1'b1 || data_cpu_to_noc_vld !== 1'b0 || data_noc_to_cpu_rdy !== 1'b0 ||
        req_log.size() != N_TX)
      begin miscompares++; $display("[TB] FAIL done_sticky: got done %b vld %b rdy %b pushes %0d required 1 0 0 %0d",
        transactions_done, data_cpu_to_noc_vld, data_noc_to_cpu_rdy, req_log.size(), N_TX); end
  endtask

  // Withheld responses cap the issue window, one response reopens it.
  task automatic test_outstanding();
    bit to;
    do_reset();
    cpu_index = $urandom;
    data_cpu_to_noc_rdy = 1'b1;
    start_traffic();
    repeat (15) tick();
    vectors++;
    if (req_log.size() != MAX_OUT || data_cpu_to_noc_vld !== 1'b0)
      begin miscompares++; $display("[TB] FAIL outstanding_cap: got pushes %0d vld %b required %0d 0",
        req_log.size(), data_cpu_to_noc_vld, MAX_OUT); end
    data_noc_to_cpu_vld = 1'b1;
    data_noc_to_cpu     = req_log[0];
    tick();
    data_noc_to_cpu_vld = 1'b0;
    repeat (3) tick();
    vectors++;
    if (req_log.size() != MAX_OUT + 1 || rx_count !== 16'd1)
      begin miscompares++; $display("[TB] FAIL outstanding_resume: got pushes %0d rx %0d required %0d 1",
        req_log.size(), rx_count, MAX_OUT + 1); end
    for (int i = 1; i < req_log.size(); i++) resp_q.push_back(req_log[i]);
    pushes = req_log.size();
    pulls  = 1;
    run_traffic(0, -1, 0, 300, to);
    vectors++;
    if (to || transactions_done !== 1'b1 || error !== 1'b0 || limit_viol != 0)
      begin miscompares++; $display("[TB] FAIL outstanding_finish: got timeout %b done %b err %b limit %0d required 0 1 0 0",
        to, transactions_done, error, limit_viol); end
  endtask

  // Bit 0 of the second response flipped: error rises next cycle and sticks.
  task automatic test_corrupt();
    test_full_run("corrupt", 0, 1);
    vectors++;
    if (err_before_c !== 1'b0 || err_after_c !== 1'b1 || err_dropped)
      begin miscompares++; $display("[TB] FAIL corrupt_timing: got before %b after %b dropped %b required 0 1 0",
        err_before_c, err_after_c, err_dropped); end
  endtask

  // A response with nothing outstanding flags error and counts nothing.
  task automatic test_unsolicited();
    do_reset();
    cpu_index = $urandom;
    data_cpu_to_noc_rdy = 1'b0;
    start_traffic();
    data_noc_to_cpu_vld = 1'b1;
    data_noc_to_cpu     = {$urandom, $urandom};
    tick();
    data_noc_to_cpu_vld = 1'b0;
    tick();
    vectors++;
    if (error !== 1'b1 || rx_count !== 16'd0 || req_log.size() != 0)
      begin miscompares++; $display("[TB] FAIL unsolicited: got err %b rx %0d pushes %0d required 1 0 0",
        error, rx_count, req_log.size()); end
  endtask

  // Toggling push ready with IDLE_GAP in force.
  task automatic test_gap_backpressure();
    test_full_run("gap_bp", 1, -1);
  endtask

  // Randomized push ready and response timing over several runs.
  task automatic test_random();
    for (int r = 0; r < 3; r++) test_full_run("random", 2, -1);
  endtask

  // Reset after two accepts clears outputs at once; the restart begins at seq 0.
  task automatic test_reset_midrun();
    bit to;
    do_reset();
    cpu_index = $urandom;
    start_traffic();
    run_traffic(0, -1, 2, 50, to);
    vectors++;
    if (to) begin miscompares++; $display("[TB] FAIL midrun_prefill: got %0d pushes required 2", req_log.size()); end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({data_cpu_to_noc_vld, data_noc_to_cpu_rdy, transactions_done, error} !== 4'b0 ||
        data_cpu_to_noc !== 64'd0 || rx_count !== 16'd0)
      begin miscompares++; $display("[TB] FAIL midrun_reset: got flags %b data %h rx %0d required 0000 0 0",
        {data_cpu_to_noc_vld, data_noc_to_cpu_rdy, transactions_done, error}, data_cpu_to_noc, rx_count); end
    @(negedge clk);
    do_reset();
    start_traffic();
    run_traffic(2, -1, 0, 400, to);
    vectors++;
    if (to || req_log.size() == 0 || req_log[0] !== exp_word(cpu_index, 0))
      begin miscompares++; $display("[TB] FAIL midrun_restart: got timeout %b first %h required 0 %h",
        to, (req_log.size() > 0) ? req_log[0] : 64'd0, exp_word(cpu_index, 0)); end
    vectors++;
    if (transactions_done !== 1'b1 || rx_count !== 16'(N_TX) || error !== 1'b0)
      begin miscompares++; $display("[TB] FAIL midrun_done: got done %b rx %0d err %b required 1 %0d 0",
        transactions_done, rx_count, error, N_TX); end
  endtask

  // Scenario sequence and final summary.
  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    start       = 1'b0;
    cpu_index   = '0;
    data_cpu_to_noc_rdy = 1'b0;
    data_noc_to_cpu_vld = 1'b0;
    data_noc_to_cpu     = '0;
    test_reset();
    test_basic_echo();
    test_outstanding();
    test_corrupt();
    test_unsolicited();
    test_gap_backpressure();
    test_random();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
